// File: rtl/win_sprite_addr_gen.sv
// Window sprite address generator.
// Accepts one pixel per cycle and reports whether it falls inside the sprite
// at the position chosen by start_i. When it does, it also returns the sprite
// ROM address for that pixel. The result appears two cycles later.
// Optional build macro WIN_SPRITE_BLINK_EN adds a blink phase that toggles
// each time the animation frame index wraps to 0. While the phase is set, the
// sprite is hidden.
module win_sprite_addr_gen #(
    parameter int                       SPR_W           = 36,
    parameter int                       SPR_H           = 28,
    parameter int                       NUM_POS         = 4,
    parameter logic [NUM_POS*10-1:0]    POS_X           = {10'd576, 10'd30, 10'd576, 10'd31},
    parameter logic [NUM_POS*10-1:0]    POS_Y           = {10'd103, 10'd240, 10'd240, 10'd103},
    parameter int                       NUM_FRAMES      = 2,
    parameter int                       TICKS_PER_FRAME = 8,
    parameter int                       ADDR_W          = 17
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [2:0]        start_i,
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    input  logic              in_valid_i,
    input  logic              frame_tick_i,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic              hit_o,
    output logic              out_valid_o
);

    localparam int FW       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int TW       = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam int FRAME_SZ = SPR_W * SPR_H;

    // animation counters
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [FW-1:0] frame_idx_q, frame_idx_d;
    logic          frame_wrap;

    // stage 1
    logic          s1_valid_q, s1_valid_d;
    logic          s1_match_q, s1_match_d;
    logic [9:0]    s1_xw_q, s1_xw_d;
    logic [9:0]    s1_yw_q, s1_yw_d;
    logic [FW-1:0] s1_frame_q, s1_frame_d;

    // stage 2
    logic              out_valid_q, out_valid_d;
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // position lookup
    logic       pos_sel;
    logic [9:0] pos_x, pos_y;
    logic       in_x, in_y, match;
    logic       hidden;

`ifdef WIN_SPRITE_BLINK_EN
    logic blink_phase_q, blink_phase_d;

    // blink phase flips on every frame-index wrap
    always_comb begin
        blink_phase_d = blink_phase_q;
        if (frame_wrap) begin
            blink_phase_d = ~blink_phase_q;
        end
    end

    // blink phase register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            blink_phase_q <= 1'b0;
        end else begin
            blink_phase_q <= blink_phase_d;
        end
    end

    assign hidden = blink_phase_q;
`else
    assign hidden = 1'b0;
`endif

    // tick counter and frame index advance on frame_tick
    always_comb begin
        tick_cnt_d  = tick_cnt_q;
        frame_idx_d = frame_idx_q;
        frame_wrap  = 1'b0;
        if (frame_tick_i) begin
            if (tick_cnt_q == TW'(TICKS_PER_FRAME - 1)) begin
                tick_cnt_d = '0;
                if (frame_idx_q == FW'(NUM_FRAMES - 1)) begin
                    frame_idx_d = '0;
                    frame_wrap  = 1'b1;
                end else begin
                    frame_idx_d = frame_idx_q + 1'b1;
                end
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    // decode start into a position and test the pixel against its box (11-bit, no wrap)
    always_comb begin
        pos_sel = 1'b0;
        pos_x   = '0;
        pos_y   = '0;
        for (int i = 0; i < NUM_POS; i++) begin
            if (int'(start_i) == i + 2) begin
                pos_sel = 1'b1;
                pos_x   = POS_X[i*10 +: 10];
                pos_y   = POS_Y[i*10 +: 10];
            end
        end
        in_x  = ({1'b0, x_i} >= {1'b0, pos_x}) &&
                ({1'b0, x_i} <  ({1'b0, pos_x} + 11'(SPR_W)));
        in_y  = ({1'b0, y_i} >= {1'b0, pos_y}) &&
                ({1'b0, y_i} <  ({1'b0, pos_y} + 11'(SPR_H)));
        match = pos_sel & in_x & in_y;
    end

    // stage 1 capture; the frame snapshot is the pre-update value
    always_comb begin
        s1_valid_d = in_valid_i;
        s1_match_d = in_valid_i & match & ~hidden;
        s1_xw_d    = '0;
        s1_yw_d    = '0;
        s1_frame_d = frame_idx_q;
        if (s1_match_d) begin
            s1_xw_d = x_i - pos_x;
            s1_yw_d = y_i - pos_y;
        end
    end

    // stage 2 address arithmetic; misses force a zero address
    always_comb begin
        out_valid_d = s1_valid_q;
        hit_d       = s1_valid_q & s1_match_q;
        addr_d      = '0;
        if (hit_d) begin
            addr_d = ADDR_W'(s1_frame_q) * ADDR_W'(FRAME_SZ) +
                     ADDR_W'(s1_yw_q)    * ADDR_W'(SPR_W) +
                     ADDR_W'(s1_xw_q);
        end
    end

    // pipeline and counter registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tick_cnt_q  <= '0;
            frame_idx_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_match_q  <= 1'b0;
            s1_xw_q     <= '0;
            s1_yw_q     <= '0;
            s1_frame_q  <= '0;
            out_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            addr_q      <= '0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            frame_idx_q <= frame_idx_d;
            s1_valid_q  <= s1_valid_d;
            s1_match_q  <= s1_match_d;
            s1_xw_q     <= s1_xw_d;
            s1_yw_q     <= s1_yw_d;
            s1_frame_q  <= s1_frame_d;
            out_valid_q <= out_valid_d;
            hit_q       <= hit_d;
            addr_q      <= addr_d;
        end
    end

    assign mem_address_o = addr_q;
    assign hit_o         = hit_q;
    assign out_valid_o   = out_valid_q;

endmodule

// File: tb/tb_win_sprite_addr_gen.sv
// Randomised and directed bench for win_sprite_addr_gen against a
// behavioural model built from box geometry and total tick count.
module tb_win_sprite_addr_gen;

    localparam int SPR_W  = 36;
    localparam int SPR_H  = 28;
    localparam int NPOS   = 4;
    localparam int NFR    = 2;
    localparam int TPF    = 8;
    localparam int ADDR_W = 17;

    int pos_x [NPOS] = '{31, 576, 30, 576};
    int pos_y [NPOS] = '{103, 240, 240, 103};

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        start;
    logic [9:0]        x, y;
    logic              in_valid, frame_tick;
    logic [ADDR_W-1:0] mem_address;
    logic              hit, out_valid;

    int n_vec  = 0;
    int n_fail = 0;

    // model state
    int ticks = 0;
    int e1_v = 0, e1_h = 0, e1_a = 0;
    int e2_v = 0, e2_h = 0, e2_a = 0;

    win_sprite_addr_gen dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .x_i          (x),
        .y_i          (y),
        .in_valid_i   (in_valid),
        .frame_tick_i (frame_tick),
        .mem_address_o(mem_address),
        .hit_o        (hit),
        .out_valid_o  (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // expected result of one pixel given the ticks seen so far
    task automatic model(input int st, input int xx, input int yy, input int v,
                         output int ev, output int eh, output int ea);
        int p, frame, blink;
        p     = st - 2;
        frame = (ticks / TPF) % NFR;
`ifdef WIN_SPRITE_BLINK_EN
        blink = (ticks / (TPF * NFR)) % 2;
`else
        blink = 0;
`endif
        ev = v;
        eh = 0;
        ea = 0;
        if (v != 0 && p >= 0 && p < NPOS && blink == 0 &&
            xx >= pos_x[p] && xx < pos_x[p] + SPR_W &&
            yy >= pos_y[p] && yy < pos_y[p] + SPR_H) begin
            eh = 1;
            ea = (frame * SPR_W * SPR_H + (yy - pos_y[p]) * SPR_W + (xx - pos_x[p]))
                 % (1 << ADDR_W);
        end
    endtask

    // one clock: check the slot now at the outputs, then apply new inputs
    task automatic cycle(input int rst, input int st, input int xx, input int yy,
                         input int v, input int ft, input string tag);
        int mv, mh, ma;
        @(negedge clk);
        chk({tag, ".valid"}, int'(out_valid),   e2_v);
        chk({tag, ".hit"},   int'(hit),         e2_h);
        chk({tag, ".addr"},  int'(mem_address), e2_a);
        reset      = rst[0];
        start      = st[2:0];
        x          = xx[9:0];
        y          = yy[9:0];
        in_valid   = v[0];
        frame_tick = ft[0];
        model(st, xx, yy, v, mv, mh, ma);
        if (rst != 0) begin
            e2_v = 0; e2_h = 0; e2_a = 0;
            e1_v = 0; e1_h = 0; e1_a = 0;
            ticks = 0;
        end else begin
            e2_v = e1_v; e2_h = e1_h; e2_a = e1_a;
            e1_v = mv;   e1_h = mh;   e1_a = ma;
            if (ft != 0) ticks++;
        end
    endtask

    task automatic idle(input int n, input int ft, input string tag);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, ft, tag);
    endtask

    initial begin
        int p, st, xx, yy, v, ft, rst;
        reset = 1'b1; start = '0; x = '0; y = '0; in_valid = 1'b0; frame_tick = 1'b0;
        @(posedge clk);
        @(posedge clk);

        // reset state and pixel at the first position's origin
        cycle(1, 0, 0, 0, 0, 0, "rst");
        cycle(0, 2, 31, 103, 1, 0, "origin");
        idle(2, 0, "origin_out");

        // inside corner, one past the right edge, and the bottom edge
        cycle(0, 2, 66, 130, 1, 0, "corner");
        cycle(0, 2, 67, 130, 1, 0, "right_edge");
        cycle(0, 2, 66, 131, 1, 0, "bottom_edge");
        cycle(0, 2, 30, 103, 1, 0, "left_edge");

        // other positions and out-of-range selectors
        cycle(0, 3, 31, 103, 1, 0, "pos1_miss");
        cycle(0, 3, 576, 240, 1, 0, "pos1_hit");
        cycle(0, 6, 31, 103, 1, 0, "sel6");
        cycle(0, 7, 576, 240, 1, 0, "sel7");
        cycle(0, 0, 31, 103, 1, 0, "sel0");
        cycle(0, 1, 31, 103, 1, 0, "sel1");
        cycle(0, 2, 31, 103, 0, 0, "novalid");
        idle(2, 0, "drain");

        // frame advance after 8 ticks, back to frame 0 after 8 more
        idle(8, 1, "tick8");
        cycle(0, 5, 577, 104, 1, 0, "frame1");
        idle(8, 1, "tick16");
        cycle(0, 5, 577, 104, 1, 0, "frame0");
        idle(2, 0, "drain2");

        // tick coincident with a pixel uses the old frame
        idle(7, 1, "tick7");
        cycle(0, 2, 40, 110, 1, 1, "tick_coinc");
        cycle(0, 2, 40, 110, 1, 0, "after_coinc");
        idle(2, 0, "drain3");

        // mid-stream reset flushes two slots
        for (int i = 0; i < 4; i++) cycle(0, 2, 31 + i, 103 + i, 1, i % 2, "stream");
        cycle(1, 2, 35, 107, 1, 0, "midrst");
        for (int i = 0; i < 4; i++) cycle(0, 2, 36 + i, 108, 1, 0, "post_rst");
        idle(2, 0, "drain4");

        // randomised traffic
        for (int n = 0; n < 400; n++) begin
            p   = int'($urandom_range(0, NPOS - 1));
            st  = int'($urandom_range(0, 7));
            xx  = pos_x[p] + int'($urandom_range(0, SPR_W + 4)) - 2;
            yy  = pos_y[p] + int'($urandom_range(0, SPR_H + 4)) - 2;
            if ($urandom_range(0, 9) == 0) begin
                xx = int'($urandom_range(0, 1023));
                yy = int'($urandom_range(0, 1023));
            end
            v   = ($urandom_range(0, 4) != 0) ? 1 : 0;
            ft  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            rst = ($urandom_range(0, 79) == 0) ? 1 : 0;
            cycle(rst, st, xx, yy, v, ft, "rand");
        end
        idle(2, 0, "final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
